// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder: rebuilds four BCD clock digits from the multiplexed, PWM-dimmed,
// active-low seven-segment bus; debounces across scans and flags bad or stalled activity.
module ss_scan_decoder #(
   parameter int MIN_ON       = 4,
   parameter int STABLE_SCANS = 3,
   parameter int TIMEOUT_CYC  = 2_000_000
) (
   input  logic       CLK100MHZ,
   input  logic       reset_n,
   input  logic [3:0] AN,
   input  logic [6:0] SEG,
   input  logic       clr_err,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic       all_valid,
   output logic       time_valid,
   output logic       update,
   output logic       pattern_err,
   output logic       overlap_err,
   output logic       stale
);
   localparam int CW = $clog2(MIN_ON + 1);
   localparam int SW = $clog2(STABLE_SCANS + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_ON);
   localparam logic [SW-1:0] STB   = SW'(STABLE_SCANS);
   localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_CYC);

   // {illegal, bcd}
   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h40:   return 5'h00;
         7'h79:   return 5'h01;
         7'h24:   return 5'h02;
         7'h30:   return 5'h03;
         7'h19:   return 5'h04;
         7'h12:   return 5'h05;
         7'h02:   return 5'h06;
         7'h78:   return 5'h07;
         7'h00:   return 5'h08;
         7'h10:   return 5'h09;
         default: return 5'h1F;
      endcase
   endfunction

   logic [3:0]    an_q;
   logic [6:0]    seg_q, pat_q, pat_d;
   logic          open_q, open_d, have_q, have_d, conf_q, conf_d;
   logic [1:0]    widx_q, widx_d, idx;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [3:0]    dig_q [4];
   logic [3:0]    dig_d [4];
   logic [3:0]    cand_q [4];
   logic [3:0]    cand_d [4];
   logic [SW-1:0] mcnt_q [4];
   logic [SW-1:0] mcnt_d [4];
   logic          pe_ev_q, pe_ev_d, pattern_err_q, pattern_err_d;
   logic          overlap_err_q, overlap_err_d, update_q, update_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          single, multi, lit, sw, close, short_win, bad;
   logic [4:0]    dec;
   logic [3:0]    dec_val;

   always_comb begin
      single = 1'b1;
      idx = 2'd0;
      case (an_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: single = 1'b0;
      endcase
   end

   assign multi     = ~single & (an_q != 4'hF);
   assign lit       = single & (seg_q != 7'h7F);
   assign sw        = single & (~open_q | (idx != widx_q));
   assign close     = sw & open_q;
   assign stale     = tcnt_q == TMO;
   assign dec       = seg_decode(pat_q);
   assign short_win = wcnt_q != MIN_C;
   assign dec_val   = short_win ? 4'hF : dec[3:0];
   assign bad       = ~conf_q & ~short_win & dec[4];

   always_comb begin
      // a stall drops the open window so the first window after it closes nothing
      open_d = single | (open_q & ~stale);
      widx_d = single ? idx : widx_q;
      wcnt_d = sw ? CW'(lit) : wcnt_q + CW'(lit && wcnt_q != MIN_C);
      pat_d = (lit & (sw | ~have_q)) ? seg_q : pat_q;
      have_d = sw ? lit : (have_q | lit);
      conf_d = ~sw & (conf_q | (lit & have_q & (seg_q != pat_q)));
      cand_d = cand_q;
      mcnt_d = mcnt_q;
      dig_d = dig_q;
      update_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (close && widx_q == 2'(i)) begin
            if (conf_q)
               mcnt_d[i] = '0;
            else if (dec_val == cand_q[i])
               mcnt_d[i] = (mcnt_q[i] == STB) ? STB : mcnt_q[i] + 1'b1;
            else begin
               cand_d[i] = dec_val;
               mcnt_d[i] = SW'(1);
            end
         end
         if (mcnt_q[i] == STB && cand_q[i] != dig_q[i]) begin
            dig_d[i] = cand_q[i];
            update_d = 1'b1;
         end
      end
      pe_ev_d = close & (conf_q | bad);
      pattern_err_d = pe_ev_q | (pattern_err_q & ~clr_err);
      overlap_err_d = multi | (overlap_err_q & ~clr_err);
      tcnt_d = close ? '0 : (stale ? tcnt_q : tcnt_q + 1'b1);
   end

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         an_q <= 4'hF;
         seg_q <= 7'h7F;
         open_q <= 1'b0;
         widx_q <= 2'd0;
         wcnt_q <= '0;
         pat_q <= 7'h7F;
         have_q <= 1'b0;
         conf_q <= 1'b0;
         dig_q <= '{default: 4'hF};
         cand_q <= '{default: 4'hF};
         mcnt_q <= '{default: '0};
         pe_ev_q <= 1'b0;
         pattern_err_q <= 1'b0;
         overlap_err_q <= 1'b0;
         update_q <= 1'b0;
         tcnt_q <= '0;
      end else begin
         an_q <= AN;
         seg_q <= SEG;
         open_q <= open_d;
         widx_q <= widx_d;
         wcnt_q <= wcnt_d;
         pat_q <= pat_d;
         have_q <= have_d;
         conf_q <= conf_d;
         dig_q <= dig_d;
         cand_q <= cand_d;
         mcnt_q <= mcnt_d;
         pe_ev_q <= pe_ev_d;
         pattern_err_q <= pattern_err_d;
         overlap_err_q <= overlap_err_d;
         update_q <= update_d;
         tcnt_q <= tcnt_d;
      end
   end

   assign {d3, d2, d1, d0} = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
   assign all_valid   = (d3 <= 4'd9) & (d2 <= 4'd9) & (d1 <= 4'd9) & (d0 <= 4'd9);
   assign time_valid  = all_valid & (d3 <= 4'd2) & ((d3 != 4'd2) | (d2 <= 4'd3)) & (d1 <= 4'd5);
   assign update      = update_q;
   assign pattern_err = pattern_err_q;
   assign overlap_err = overlap_err_q;
endmodule

// File: tb/tb_ss_scan_decoder.sv
// tb_ss_scan_decoder: directed scan sequences with hand-computed expectations
// for digit commit, PWM threshold, debounce, error flags, stall and reset.
module tb_ss_scan_decoder;
   localparam int TO = 3000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] AN = 4'hF;
   logic [6:0] SEG = 7'h7F;
   logic       clr_err = 1'b0;
   logic [3:0] d3, d2, d1, d0;
   logic       all_valid, time_valid, update, pattern_err, overlap_err, stale;
   logic [15:0] digs;
   int n_vec = 0, n_err = 0, upd_n = 0;

   assign digs = {d3, d2, d1, d0};
   always #5 clk = ~clk;

   ss_scan_decoder #(.MIN_ON(4), .STABLE_SCANS(3), .TIMEOUT_CYC(TO)) dut (
      .CLK100MHZ(clk), .reset_n(reset_n), .AN(AN), .SEG(SEG), .clr_err(clr_err),
      .d3(d3), .d2(d2), .d1(d1), .d0(d0), .all_valid(all_valid), .time_valid(time_valid),
      .update(update), .pattern_err(pattern_err), .overlap_err(overlap_err), .stale(stale)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] a, input logic [6:0] s);
      @(negedge clk);
      if (update === 1'b1) upd_n++;
      AN = a;
      SEG = s;
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      repeat (n) step(a, s);
   endtask

   function automatic logic [3:0] an_of(input int d);
      return ~(4'b0001 << d);
   endfunction

   task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                       input logic [6:0] p0, input int cyc, input int lit);
      logic [6:0] p [4];
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      for (int d = 3; d >= 0; d--) begin
         hold(an_of(d), p[d], lit);
         hold(an_of(d), 7'h7F, cyc - lit);
      end
   endtask

   task automatic pulse_clr;
      clr_err = 1'b1;
      step(AN, SEG);
      clr_err = 1'b0;
      hold(AN, SEG, 2);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1 chk("async_reset_digits", digs, 16'hFFFF);
      hold(4'hF, 7'h7F, 3);
      chk("reset_digits", digs, 16'hFFFF);
      chk("reset_flags", {10'd0, update, pattern_err, overlap_err, stale, all_valid, time_valid}, 16'h0);
      reset_n = 1'b1;

      // 12:34 fully lit, 1000 cycles per digit
      upd_n = 0;
      repeat (3) scan(7'h79, 7'h24, 7'h30, 7'h19, 1000, 1000);
      chk("scan3_digits", digs, 16'h123F);
      chk("scan3_updates", 16'(upd_n), 16'd3);
      scan(7'h79, 7'h24, 7'h30, 7'h19, 1000, 1000);
      chk("1234_digits", digs, 16'h1234);
      chk("1234_updates", 16'(upd_n), 16'd4);
      chk("1234_all_valid", 16'(all_valid), 16'd1);
      chk("1234_time_valid", 16'(time_valid), 16'd1);

      // PWM threshold
      upd_n = 0;
      repeat (4) scan(7'h79, 7'h24, 7'h30, 7'h19, 200, 4);
      chk("pwm4_digits", digs, 16'h1234);
      chk("pwm4_updates", 16'(upd_n), 16'd0);
      repeat (4) scan(7'h79, 7'h24, 7'h30, 7'h19, 200, 3);
      chk("pwm3_digits", digs, 16'hFFFF);
      chk("pwm3_updates", 16'(upd_n), 16'd4);
      chk("pwm3_all_valid", 16'(all_valid), 16'd0);

      // single-scan glitch, then a held change with exact commit latency
      upd_n = 0;
      repeat (4) scan(7'h79, 7'h24, 7'h30, 7'h19, 100, 100);
      chk("recommit_digits", digs, 16'h1234);
      chk("recommit_updates", 16'(upd_n), 16'd4);
      upd_n = 0;
      scan(7'h79, 7'h24, 7'h30, 7'h12, 100, 100);
      repeat (3) scan(7'h79, 7'h24, 7'h30, 7'h19, 100, 100);
      chk("glitch_digits", digs, 16'h1234);
      chk("glitch_updates", 16'(upd_n), 16'd0);
      repeat (3) scan(7'h79, 7'h24, 7'h30, 7'h12, 100, 100);
      upd_n = 0;
      step(an_of(3), 7'h79);
      hold(an_of(3), 7'h79, 2);
      chk("hold5_n2_d0", 16'(d0), 16'h4);
      chk("hold5_n2_update", 16'(upd_n), 16'd0);
      step(an_of(3), 7'h79);
      chk("hold5_n3_d0", 16'(d0), 16'h5);
      chk("hold5_n3_update", 16'(upd_n), 16'd1);
      hold(an_of(3), 7'h79, 96);
      hold(an_of(2), 7'h24, 100);
      hold(an_of(1), 7'h30, 100);
      hold(an_of(0), 7'h12, 100);
      chk("hold5_digits", digs, 16'h1235);
      chk("hold5_updates", 16'(upd_n), 16'd1);

      // illegal pattern in d1
      repeat (3) scan(7'h79, 7'h24, 7'h7E, 7'h12, 100, 100);
      chk("illegal_perr", 16'(pattern_err), 16'd1);
      chk("illegal_digits", digs, 16'h12F5);
      chk("illegal_all_valid", 16'(all_valid), 16'd0);
      chk("illegal_time_valid", 16'(time_valid), 16'd0);
      scan(7'h79, 7'h24, 7'h30, 7'h12, 100, 100);
      pulse_clr();
      chk("clr_perr", 16'(pattern_err), 16'd0);

      // conflicting patterns in one d2 window
      hold(an_of(3), 7'h79, 100);
      hold(an_of(2), 7'h40, 50);
      hold(an_of(2), 7'h79, 50);
      hold(an_of(1), 7'h30, 100);
      hold(an_of(0), 7'h12, 100);
      chk("conflict_perr", 16'(pattern_err), 16'd1);
      repeat (2) scan(7'h79, 7'h40, 7'h30, 7'h12, 100, 100);
      chk("conflict_discard_d2", 16'(d2), 16'h2);
      chk("conflict_digits", digs, 16'h1235);
      pulse_clr();
      chk("clr2_perr", 16'(pattern_err), 16'd0);

      // overlap and stall
      step(4'b1100, 7'h79);
      step(4'hF, 7'h7F);
      chk("overlap_n1", 16'(overlap_err), 16'd0);
      step(4'hF, 7'h7F);
      chk("overlap_n2", 16'(overlap_err), 16'd1);
      hold(4'hF, 7'h7F, TO + 2);
      chk("stale_set", 16'(stale), 16'd1);
      hold(an_of(3), 7'h79, 10);
      chk("stale_first_window", 16'(stale), 16'd1);
      hold(an_of(3), 7'h79, 90);
      step(an_of(2), 7'h24);
      hold(an_of(2), 7'h24, 2);
      chk("stale_clear", 16'(stale), 16'd0);
      hold(an_of(2), 7'h24, 97);
      hold(an_of(1), 7'h30, 100);
      hold(an_of(0), 7'h12, 100);
      pulse_clr();
      chk("clr_overlap", 16'(overlap_err), 16'd0);

      // reset while a window is open
      repeat (4) scan(7'h79, 7'h24, 7'h30, 7'h19, 100, 100);
      chk("pre_reset_digits", digs, 16'h1234);
      hold(an_of(3), 7'h79, 100);
      hold(an_of(2), 7'h24, 30);
      step(4'b1100, 7'h24);
      hold(an_of(2), 7'h24, 5);
      chk("pre_reset_overlap", 16'(overlap_err), 16'd1);
      #2 reset_n = 1'b0;
      #1 chk("mid_reset_digits", digs, 16'hFFFF);
      chk("mid_reset_flags", {10'd0, update, pattern_err, overlap_err, stale, all_valid, time_valid}, 16'h0);
      hold(an_of(2), 7'h24, 3);
      reset_n = 1'b1;
      upd_n = 0;
      hold(an_of(2), 7'h24, 20);
      hold(an_of(1), 7'h30, 100);
      hold(an_of(0), 7'h19, 100);
      repeat (3) scan(7'h79, 7'h24, 7'h30, 7'h19, 100, 100);
      chk("post_reset_digits", digs, 16'h1234);
      chk("post_reset_updates", 16'(upd_n), 16'd4);
      chk("post_reset_time_valid", 16'(time_valid), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
